// File: rtl/cv_frame_sched.sv
// Frame-level owner scheduler for the single-port capture frame buffer: capture core vs. reader.
// Define CV_SCHED_RD_TIMEOUT_EN to revoke a read window after RD_TIMEOUT_FRAMES frame boundaries.
module cv_frame_sched #(
  parameter int unsigned ADDR_W            = 19,
  parameter int unsigned DATA_W            = 4,
  parameter int unsigned DECIM             = 1,
  parameter int unsigned CNT_W             = 8,
  parameter int unsigned RD_TIMEOUT_FRAMES = 4
) (
  input  logic              clk24,
  input  logic              rst,
  input  logic              enable,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_end,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StWaitSof = 2'b01,
    StCapture = 2'b10,
    StRead    = 2'b11
  } state_e;

  localparam logic [3:0] DecimL = 4'(DECIM);

  state_e              state_q, state_d;
  logic [3:0]          dec_q, dec_d, dec_inc;
  logic [CNT_W-1:0]    frame_q, frame_d, drop_q, drop_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                rd_s1_q, rd_valid_q;
  logic                timeout_hit;

`ifdef CV_SCHED_RD_TIMEOUT_EN
  localparam logic [7:0] ToLimit = 8'(RD_TIMEOUT_FRAMES);
  logic [7:0] to_q, to_d;
  logic       rd_abort_q;

  // Held at zero outside READ, so it restarts from zero on every READ entry.
  always_comb begin
    to_d = to_q;
    if (state_q != StRead) begin
      to_d = '0;
    end else if (core_end) begin
      to_d = to_q + 8'd1;
    end
    timeout_hit = (state_q == StRead) && core_end && !rd_done && (to_q + 8'd1 == ToLimit);
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      to_q       <= '0;
      rd_abort_q <= 1'b0;
    end else begin
      to_q       <= to_d;
      rd_abort_q <= timeout_hit;
    end
  end

  assign rd_abort = rd_abort_q;
`else
  assign timeout_hit = 1'b0;
  assign rd_abort    = 1'b0;
`endif

  always_ff @(posedge clk24) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturates at DECIM so a late rd_req still gets the window at a later boundary.
  assign dec_inc = (dec_q >= DecimL) ? DecimL : dec_q + 4'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (enable) state_d = StWaitSof;
      StWaitSof: begin
        if (!enable)       state_d = StIdle;
        else if (core_end) state_d = StCapture;
      end
      StCapture: begin
        if (core_end) begin
          if (!enable)                         state_d = StIdle;
          else if (rd_req && dec_inc >= DecimL) state_d = StRead;
        end
      end
      StRead: begin
        if (rd_done)          state_d = core_end ? StCapture : StWaitSof;
        else if (timeout_hit) state_d = StCapture;
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_grant = (state_q == StRead);
    state_o  = state_q;
  end

  // Writes pass only while CAPTURE persists across the edge, so every handover sees mem_we=0.
  always_comb begin
    dec_d      = dec_q;
    frame_d    = frame_q;
    drop_d     = drop_q;
    mem_we_d   = core_we && (state_q == StCapture) && (state_d == StCapture);
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (state_q == StCapture) begin
      mem_addr_d = core_addr;
      mem_din_d  = core_dout;
      if (core_end) begin
        frame_d = frame_q + CNT_W'(1);
        dec_d   = (state_d == StRead) ? 4'd0 : dec_inc;
      end
    end else if (state_q == StRead) begin
      if (rd_req) mem_addr_d = rd_addr;
      if (core_end && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      dec_q      <= '0;
      frame_q    <= '0;
      drop_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd_s1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      dec_q      <= dec_d;
      frame_q    <= frame_d;
      drop_q     <= drop_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rd_s1_q    <= rd_req && rd_grant;
      rd_valid_q <= rd_s1_q;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? mem_dout : '0;

endmodule

// File: tb/tb_cv_frame_sched.sv
// Bench for cv_frame_sched: directed stimulus, read data checked through a scoreboard queue.
// Two instances: DECIM=1 for the main flow, DECIM=3 for decimation, each held in reset in turn.
module tb_cv_frame_sched;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;

  logic clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  logic          rst = 1'b1, rst3 = 1'b1;
  logic          enable = 1'b0, core_we = 1'b0, core_end = 1'b0;
  logic          rd_req = 1'b0, rd_done = 1'b0;
  logic [AW-1:0] core_addr = '0, rd_addr = '0;
  logic [DW-1:0] core_dout = '0;

  logic          rd_grant, rd_valid, rd_abort, mem_we;
  logic [DW-1:0] rd_data, mem_din;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] frame_cnt, drop_cnt;
  logic [1:0]    state_o;
  logic [DW-1:0] mem_dout = '0;

  logic          rd_grant3, rd_valid3, rd_abort3, mem_we3;
  logic [DW-1:0] rd_data3, mem_din3;
  logic [AW-1:0] mem_addr3;
  logic [CW-1:0] frame_cnt3, drop_cnt3;
  logic [1:0]    state3;

  cv_frame_sched #(.ADDR_W(AW), .DATA_W(DW), .DECIM(1), .CNT_W(CW), .RD_TIMEOUT_FRAMES(4)) dut (
    .clk24(clk24), .rst(rst), .enable(enable), .core_we(core_we), .core_addr(core_addr),
    .core_dout(core_dout), .core_end(core_end), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_abort(rd_abort), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .state_o(state_o)
  );

  cv_frame_sched #(.ADDR_W(AW), .DATA_W(DW), .DECIM(3), .CNT_W(CW), .RD_TIMEOUT_FRAMES(4)) dut3 (
    .clk24(clk24), .rst(rst3), .enable(enable), .core_we(core_we), .core_addr(core_addr),
    .core_dout(core_dout), .core_end(core_end), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_grant(rd_grant3), .rd_valid(rd_valid3), .rd_data(rd_data3),
    .rd_abort(rd_abort3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_din(mem_din3),
    .mem_dout(mem_dout), .frame_cnt(frame_cnt3), .drop_cnt(drop_cnt3), .state_o(state3)
  );

  // 1-cycle synchronous single-port RAM, read-before-write.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk24) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk24) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] pix(input int a);
    return DW'(a * 7 + 3);
  endfunction

  always @(negedge clk24) begin
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.data));
        chk("rd_valid_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic drive(input int a, input logic e);
    core_we   = 1'b1;
    core_addr = AW'(a);
    core_dout = pix(a);
    core_end  = e;
    tick();
    core_end  = 1'b0;
  endtask

  task automatic pulse(input logic e, input logic d);
    core_we  = 1'b0;
    core_end = e;
    rd_done  = d;
    tick();
    core_end = 1'b0;
    rd_done  = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_grant", 32'(rd_grant), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_abort", 32'(rd_abort), 32'd0);

    rst    = 1'b0;
    enable = 1'b1;
    tick();
    chk("enter_wait_sof", 32'(state_o), 32'd1);

    // Frame while waiting for the boundary: writes ignored.
    for (int a = 0; a < 10; a++) begin
      drive(a, a == 9);
      if (a < 9) chk("wait_sof_no_we", 32'(mem_we), 32'd0);
    end
    chk("sof_to_capture", 32'(state_o), 32'd2);
    chk("first_capture_cycle_we", 32'(mem_we), 32'd0);
    chk("sof_no_frame_cnt", 32'(frame_cnt), 32'd0);

    for (int f = 1; f <= 2; f++) begin
      for (int a = 0; a < 10; a++) begin
        drive(a, a == 9);
        if (f == 1 && (a == 0 || a == 5)) begin
          chk("cap_we", 32'(mem_we), 32'd1);
          chk("cap_addr", 32'(mem_addr), 32'(a));
          chk("cap_din", 32'(mem_din), 32'(pix(a)));
        end
      end
      chk("cap_stays", 32'(state_o), 32'd2);
    end
    chk("frame_cnt_2", 32'(frame_cnt), 32'd2);

    // rd_req mid-frame must wait for the boundary.
    for (int a = 100; a < 110; a++) begin
      if (a == 103) rd_req = 1'b1;
      drive(a, a == 109);
      if (a == 105) begin
        chk("no_preempt_grant", 32'(rd_grant), 32'd0);
        chk("no_preempt_state", 32'(state_o), 32'd2);
      end
    end
    chk("read_grant", 32'(rd_grant), 32'd1);
    chk("read_state", 32'(state_o), 32'd3);
    chk("handover_we", 32'(mem_we), 32'd0);
    chk("frame_cnt_3", 32'(frame_cnt), 32'd3);

    // Back-to-back reads while the core keeps streaming.
    for (int i = 0; i < 3; i++) begin
      rd_addr = AW'(100 + i);
      sb_q.push_back('{data: pix(100 + i), due: cyc + 2});
      core_we   = 1'b1;
      core_addr = AW'(200 + i);
      core_dout = pix(200 + i);
      tick();
      chk("read_we_blocked", 32'(mem_we), 32'd0);
      if (i == 0) chk("read_addr", 32'(mem_addr), 32'd100);
    end
    rd_req  = 1'b0;
    core_we = 1'b0;
    repeat (3) tick();
    chk("reads_drained", 32'(sb_q.size()), 32'd0);

    pulse(1'b1, 1'b0);
    chk("drop_1", 32'(drop_cnt), 32'd1);
    chk("drop_1_state", 32'(state_o), 32'd3);
    pulse(1'b1, 1'b0);
    chk("drop_2", 32'(drop_cnt), 32'd2);
    chk("drop_2_abort", 32'(rd_abort), 32'd0);
    pulse(1'b1, 1'b1);
    chk("done_end_drop", 32'(drop_cnt), 32'd3);
    chk("done_end_capture", 32'(state_o), 32'd2);
    chk("done_end_grant", 32'(rd_grant), 32'd0);
    chk("done_end_no_abort", 32'(rd_abort), 32'd0);
    chk("done_end_frame_cnt", 32'(frame_cnt), 32'd3);

    // Read window with no rd_done: timeout behaviour.
    rd_req = 1'b1;
    pulse(1'b1, 1'b0);
    rd_req = 1'b0;
    chk("to_enter_read", 32'(state_o), 32'd3);
    chk("to_frame_cnt", 32'(frame_cnt), 32'd4);
    for (int k = 1; k <= 3; k++) begin
      pulse(1'b1, 1'b0);
      chk("to_pre_abort", 32'(rd_abort), 32'd0);
      chk("to_pre_state", 32'(state_o), 32'd3);
    end
    pulse(1'b1, 1'b0);
`ifdef CV_SCHED_RD_TIMEOUT_EN
    chk("to_abort_pulse", 32'(rd_abort), 32'd1);
    chk("to_abort_state", 32'(state_o), 32'd2);
    chk("to_abort_grant", 32'(rd_grant), 32'd0);
    tick();
    chk("to_abort_single", 32'(rd_abort), 32'd0);
`else
    chk("to_no_abort", 32'(rd_abort), 32'd0);
    chk("to_stays_read", 32'(state_o), 32'd3);
    tick();
    chk("to_still_read", 32'(state_o), 32'd3);
`endif
    chk("to_drop_7", 32'(drop_cnt), 32'd7);

    // Prolonged READ: drop_cnt must saturate; re-request after any abort.
    for (int i = 0; i < 600; i++) begin
      rd_req   = !rd_grant;
      core_end = 1'b1;
      tick();
      core_end = 1'b0;
      rd_req   = 1'b0;
      tick();
    end
    chk("drop_saturates", 32'(drop_cnt), 32'd255);

    rst = 1'b1;
    tick();
    chk("rst_mid_grant", 32'(rd_grant), 32'd0);
    chk("rst_mid_state", 32'(state_o), 32'd0);
    chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
    chk("rst_mid_abort", 32'(rd_abort), 32'd0);

    // DECIM=3 instance.
    chk("d3_rst_state", 32'(state3), 32'd0);
    enable = 1'b1;
    rst3   = 1'b0;
    tick();
    chk("d3_wait_sof", 32'(state3), 32'd1);
    rd_req = 1'b1;
    pulse(1'b1, 1'b0);
    chk("d3_capture", 32'(state3), 32'd2);
    for (int c = 1; c <= 2; c++) begin
      pulse(1'b1, 1'b0);
      chk("d3_hold_capture", 32'(state3), 32'd2);
    end
    pulse(1'b1, 1'b0);
    chk("d3_read_after_3", 32'(state3), 32'd3);
    chk("d3_frame_3", 32'(frame_cnt3), 32'd3);
    pulse(1'b1, 1'b1);
    chk("d3_done_end", 32'(state3), 32'd2);
    chk("d3_drop_1", 32'(drop_cnt3), 32'd1);
    for (int c = 4; c <= 5; c++) begin
      pulse(1'b1, 1'b0);
      chk("d3_hold_capture_2", 32'(state3), 32'd2);
    end
    pulse(1'b1, 1'b0);
    chk("d3_read_after_6", 32'(state3), 32'd3);
    chk("d3_frame_6", 32'(frame_cnt3), 32'd6);
    pulse(1'b1, 1'b1);
    chk("d3_drop_2", 32'(drop_cnt3), 32'd2);
    enable = 1'b0;
    repeat (2) tick();
    chk("d3_disable_waits", 32'(state3), 32'd2);
    pulse(1'b1, 1'b0);
    chk("d3_idle_at_end", 32'(state3), 32'd0);
    chk("d3_frame_7", 32'(frame_cnt3), 32'd7);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
